// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one single-port, variable-latency memory between the instruction-fetch
// port (i_*) and the load/store port (d_*). One transaction is in flight at a
// time; conflicts are resolved round-robin. A response that does not arrive
// within MAX_WAIT cycles is aborted and ERR_DATA is returned to the owner.
//
// Ports:
//   clk, reset_n                  clock, synchronous active-low reset
//   i_req/i_addr                  fetch request (held until i_gnt)
//   i_gnt/i_rvalid/i_rdata        fetch accept pulse, response pulse, data
//   d_req/d_we/d_addr/d_wdata     data request (held until d_gnt)
//   d_gnt/d_rvalid/d_rdata        data accept pulse, response pulse, load data
//   m_req/m_we/m_addr/m_wdata     memory request side
//   m_ready/m_rvalid/m_rdata      memory accept, response pulse, read data
//   busy                          transaction in progress
//   timeout_err                   sticky flag: a response timed out since reset
module mem_port_arbiter #(
    parameter int unsigned MAX_WAIT = 255,
    parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_gnt,
    output logic        i_rvalid,
    output logic [31:0] i_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic        m_req,
    output logic        m_we,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    input  logic        m_ready,
    input  logic        m_rvalid,
    input  logic [31:0] m_rdata,
    output logic        busy,
    output logic        timeout_err
);

    localparam int unsigned CNT_W = 8;
    // Last WAIT_RESP cycle index before the response is declared lost
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(MAX_WAIT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    // Owner encoding: 0 = fetch, 1 = data
    state_t             r_state;
    logic               r_owner;
    logic               r_last_owner;
    logic               r_we;
    logic [31:0]        r_addr;
    logic [31:0]        r_wdata;
    logic [CNT_W-1:0]   r_wait_cnt;
    logic               r_i_rvalid;
    logic               r_d_rvalid;
    logic [31:0]        r_i_rdata;
    logic [31:0]        r_d_rdata;
    logic               r_timeout_err;

    logic               w_issue;
    logic               w_accept;
    logic               w_pick_data;
    logic               w_timeout;
    logic               w_ret;
    logic [31:0]        w_ret_data;

    assign w_issue  = (r_state == S_ISSUE);
    assign w_accept = w_issue & m_ready;
    // On conflict the loser of the previous grant wins; a lone request always wins
    assign w_pick_data = (i_req & d_req) ? ~r_last_owner : d_req;
    assign w_timeout   = (r_wait_cnt == WAIT_LAST);
    // A real response takes priority over a timeout in the same cycle
    assign w_ret       = (r_state == S_WAIT) & (m_rvalid | w_timeout);
    assign w_ret_data  = m_rvalid ? (r_we ? 32'h0 : m_rdata) : ERR_DATA;

    // Memory-side request, driven only while issuing
    assign m_req   = w_issue;
    assign m_we    = w_issue & r_we;
    assign m_addr  = w_issue ? r_addr  : 32'h0;
    assign m_wdata = w_issue ? r_wdata : 32'h0;

    // Accept pulse goes to the owner in the same cycle as m_ready
    assign i_gnt = w_accept & ~r_owner;
    assign d_gnt = w_accept &  r_owner;

    assign i_rvalid    = r_i_rvalid;
    assign d_rvalid    = r_d_rvalid;
    assign i_rdata     = r_i_rdata;
    assign d_rdata     = r_d_rdata;
    assign busy        = (r_state != S_IDLE);
    assign timeout_err = r_timeout_err;

    // Transaction sequencer with registered response outputs
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state       <= S_IDLE;
            r_owner       <= 1'b0;
            r_last_owner  <= 1'b1;
            r_we          <= 1'b0;
            r_addr        <= 32'h0;
            r_wdata       <= 32'h0;
            r_wait_cnt    <= '0;
            r_i_rvalid    <= 1'b0;
            r_d_rvalid    <= 1'b0;
            r_i_rdata     <= 32'h0;
            r_d_rdata     <= 32'h0;
            r_timeout_err <= 1'b0;
        end else begin
            r_i_rvalid <= 1'b0;
            r_d_rvalid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_req | d_req) begin
                        r_owner <= w_pick_data;
                        r_we    <= w_pick_data & d_we;
                        r_addr  <= w_pick_data ? d_addr  : i_addr;
                        r_wdata <= w_pick_data ? d_wdata : 32'h0;
                        r_state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (m_ready) begin
                        r_last_owner <= r_owner;
                        r_wait_cnt   <= '0;
                        r_state      <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (w_ret) begin
                        if (r_owner) begin
                            r_d_rvalid <= 1'b1;
                            r_d_rdata  <= w_ret_data;
                        end else begin
                            r_i_rvalid <= 1'b1;
                            r_i_rdata  <= w_ret_data;
                        end
                        if (!m_rvalid) begin
                            r_timeout_err <= 1'b1;
                        end
                        r_state <= S_IDLE;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + CNT_W'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: table of single transactions plus hand-written
// sequences for timeout, mid-transaction reset and continuous conflicting requests.
// Expected responses are queued when stimulus is driven and checked by a monitor.
module tb_mem_port_arbiter;

    localparam int unsigned MAX_WAIT = 8;
    localparam logic [31:0] ERR_DATA = 32'hDEADBEEF;

    logic        clk;
    logic        reset_n;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_gnt;
    logic        i_rvalid;
    logic [31:0] i_rdata;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_gnt;
    logic        d_rvalid;
    logic [31:0] d_rdata;
    logic        m_req;
    logic        m_we;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic        m_ready;
    logic        m_rvalid;
    logic [31:0] m_rdata;
    logic        busy;
    logic        timeout_err;

    mem_port_arbiter #(
        .MAX_WAIT (MAX_WAIT),
        .ERR_DATA (ERR_DATA)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .i_req       (i_req),
        .i_addr      (i_addr),
        .i_gnt       (i_gnt),
        .i_rvalid    (i_rvalid),
        .i_rdata     (i_rdata),
        .d_req       (d_req),
        .d_we        (d_we),
        .d_addr      (d_addr),
        .d_wdata     (d_wdata),
        .d_gnt       (d_gnt),
        .d_rvalid    (d_rvalid),
        .d_rdata     (d_rdata),
        .m_req       (m_req),
        .m_we        (m_we),
        .m_addr      (m_addr),
        .m_wdata     (m_wdata),
        .m_ready     (m_ready),
        .m_rvalid    (m_rvalid),
        .m_rdata     (m_rdata),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        is_data;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] mdata;
        int          ready_dly;
        int          resp_dly;
        logic        mut;
        logic [31:0] exp_rdata;
    } vec_t;

    typedef struct {
        logic        port;
        logic [31:0] data;
    } exp_t;

    exp_t sb_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic is_data, input logic we, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [31:0] mdata,
                                input int ready_dly, input int resp_dly, input logic mut,
                                input logic [31:0] exp_rdata);
        vec_t v;
        v.is_data   = is_data;
        v.we        = we;
        v.addr      = addr;
        v.wdata     = wdata;
        v.mdata     = mdata;
        v.ready_dly = ready_dly;
        v.resp_dly  = resp_dly;
        v.mut       = mut;
        v.exp_rdata = exp_rdata;
        return v;
    endfunction

    // Response monitor: every rvalid must match the oldest queued expectation
    always @(negedge clk) begin
        if (i_rvalid || d_rvalid) begin
            if (i_rvalid && d_rvalid) begin
                chk("both_rvalid", 32'({i_rvalid, d_rvalid}), 32'h1);
            end else if (sb_q.size() == 0) begin
                chk("unexpected_rvalid", 32'({i_rvalid, d_rvalid}), 32'h0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("rvalid_port", 32'(d_rvalid), 32'(e.port));
                chk("rdata", e.port ? d_rdata : i_rdata, e.data);
            end
        end
    end

    task automatic do_reset();
        @(posedge clk); #1;
        reset_n = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
    endtask

    task automatic clear_reqs();
        i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
        i_addr = 32'h0; d_addr = 32'h0; d_wdata = 32'h0;
    endtask

    // One isolated transaction with configurable memory delays
    task automatic run_vec(input vec_t v);
        logic [31:0] exp_wd;
        logic        exp_we;
        exp_we = v.is_data & v.we;
        exp_wd = v.is_data ? v.wdata : 32'h0;
        @(posedge clk); #1;
        if (v.is_data) begin
            d_req = 1'b1; d_we = v.we; d_addr = v.addr; d_wdata = v.wdata;
        end else begin
            i_req = 1'b1; i_addr = v.addr;
        end
        sb_q.push_back('{port: v.is_data, data: v.exp_rdata});
        @(posedge clk); #1;
        for (int k = 0; k < v.ready_dly; k++) begin
            @(negedge clk);
            chk("m_req_hold", 32'(m_req), 32'h1);
            chk("m_addr_hold", m_addr, v.addr);
            chk("m_we_hold", 32'(m_we), 32'(exp_we));
            chk("m_wdata_hold", m_wdata, exp_wd);
            chk("early_gnt", 32'({i_gnt, d_gnt}), 32'h0);
            @(posedge clk); #1;
            if (v.mut && k == 0) begin
                if (v.is_data) begin
                    d_addr = v.addr ^ 32'h0000FFF0; d_wdata = ~v.wdata; d_we = ~v.we;
                end else begin
                    i_addr = v.addr ^ 32'h0000FFF0;
                end
            end
        end
        m_ready = 1'b1;
        @(negedge clk);
        chk("m_req_accept", 32'(m_req), 32'h1);
        chk("m_addr_accept", m_addr, v.addr);
        chk("gnt_owner", 32'({i_gnt, d_gnt}), v.is_data ? 32'h1 : 32'h2);
        @(posedge clk); #1;
        m_ready = 1'b0;
        clear_reqs();
        for (int k = 0; k < v.resp_dly; k++) begin
            @(negedge clk);
            chk("wait_busy", 32'({busy, m_req, i_rvalid, d_rvalid}), 32'h8);
            @(posedge clk); #1;
        end
        m_rvalid = 1'b1;
        m_rdata  = v.mdata;
        @(posedge clk); #1;
        m_rvalid = 1'b0;
        m_rdata  = $urandom;
        @(negedge clk);
        chk("rvalid_timing", 32'(v.is_data ? d_rvalid : i_rvalid), 32'h1);
        chk("idle_after_resp", 32'(busy), 32'h0);
    endtask

    vec_t vecs[6];

    initial begin
        logic exp_owner;
        logic got;
        logic [31:0] md;

        vecs[0] = mk(1'b0, 1'b0, 32'h10,  32'h0,        32'h00A00093, 0, 1, 1'b0, 32'h00A00093);
        vecs[1] = mk(1'b1, 1'b1, 32'h200, 32'h12345678, 32'hFFFFFFFF, 3, 0, 1'b0, 32'h0);
        vecs[2] = mk(1'b1, 1'b0, 32'h204, 32'h55AA55AA, 32'hCAFEF00D, 1, 4, 1'b0, 32'hCAFEF00D);
        vecs[3] = mk(1'b1, 1'b0, 32'h300, 32'h0,        32'h11112222, 2, 0, 1'b1, 32'h11112222);
        vecs[4] = mk(1'b0, 1'b0, 32'h14,  32'h0,        32'h00000013, 0, 0, 1'b0, 32'h00000013);
        vecs[5] = mk(1'b1, 1'b1, 32'h400, 32'h0000A5A5, 32'h0BAD0BAD, 2, 2, 1'b1, 32'h0);

        clear_reqs();
        m_ready = 1'b0; m_rvalid = 1'b0; m_rdata = 32'h0;
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;

        // Reset state
        @(negedge clk);
        chk("rst_ctrl", 32'({busy, m_req, m_we, i_gnt, d_gnt, i_rvalid, d_rvalid, timeout_err}), 32'h0);
        chk("rst_m_addr", m_addr, 32'h0);
        chk("rst_m_wdata", m_wdata, 32'h0);
        chk("rst_i_rdata", i_rdata, 32'h0);
        chk("rst_d_rdata", d_rdata, 32'h0);

        for (int i = 0; i < 6; i++) run_vec(vecs[i]);
        chk("no_timeout_yet", 32'(timeout_err), 32'h0);

        // Lost response: ERR_DATA returned MAX_WAIT+1 cycles after the grant
        @(posedge clk); #1;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h500;
        sb_q.push_back('{port: 1'b1, data: ERR_DATA});
        @(posedge clk); #1;
        m_ready = 1'b1;
        @(negedge clk);
        chk("to_gnt", 32'({i_gnt, d_gnt}), 32'h1);
        @(posedge clk); #1;
        m_ready = 1'b0;
        clear_reqs();
        for (int k = 1; k <= int'(MAX_WAIT); k++) begin
            @(negedge clk);
            chk("to_wait", 32'({busy, d_rvalid, i_rvalid}), 32'h4);
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk("to_rvalid", 32'(d_rvalid), 32'h1);
        chk("to_flag", 32'(timeout_err), 32'h1);
        chk("to_idle", 32'(busy), 32'h0);
        run_vec(vecs[4]);
        chk("to_sticky", 32'(timeout_err), 32'h1);

        // Reset during WAIT_RESP discards the transaction
        @(posedge clk); #1;
        i_req = 1'b1; i_addr = 32'h40;
        @(posedge clk); #1;
        m_ready = 1'b1;
        @(posedge clk); #1;
        m_ready = 1'b0;
        clear_reqs();
        reset_n = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(negedge clk);
        chk("mid_rst_ctrl", 32'({busy, m_req, i_gnt, d_gnt, i_rvalid, d_rvalid, timeout_err}), 32'h0);
        @(posedge clk); #1;
        m_rvalid = 1'b1; m_rdata = 32'h77777777;
        @(posedge clk); #1;
        m_rvalid = 1'b0;
        @(negedge clk);
        chk("late_rvalid_ignored", 32'({i_rvalid, d_rvalid, busy}), 32'h0);
        chk("late_rdata_ignored", i_rdata, 32'h0);

        // Continuous conflict: fetch wins first after reset, then alternate
        @(posedge clk); #1;
        i_req = 1'b1; i_addr = 32'h1000;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h2000;
        exp_owner = 1'b0;
        for (int t = 0; t < 4; t++) begin
            got = 1'b0;
            for (int w = 0; w < 10 && !got; w++) begin
                @(negedge clk);
                if (m_req) got = 1'b1;
            end
            if (!got) begin
                chk("rr_m_req_wait", 32'h0, 32'h1);
                break;
            end
            chk("rr_m_addr", m_addr, exp_owner ? 32'h2000 : 32'h1000);
            m_ready = 1'b1;
            #1;
            chk("rr_gnt", 32'({i_gnt, d_gnt}), exp_owner ? 32'h1 : 32'h2);
            md = 32'hA0000000 | 32'(t);
            sb_q.push_back('{port: exp_owner, data: md});
            @(posedge clk); #1;
            m_ready = 1'b0;
            m_rvalid = 1'b1; m_rdata = md;
            @(posedge clk); #1;
            m_rvalid = 1'b0;
            @(negedge clk);
            chk("rr_rvalid", 32'({i_rvalid, d_rvalid}), exp_owner ? 32'h1 : 32'h2);
            if (t == 3) clear_reqs();
            exp_owner = ~exp_owner;
        end

        repeat (3) @(negedge clk);
        chk("final_idle", 32'(busy), 32'h0);
        chk("sb_empty", 32'(sb_q.size()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares one single-port, variable-latency memory between the processor's instruction-fetch port and its load/store port. This supports a multi-cycle core variant with a unified instruction/data memory. The block accepts one request at a time, arbitrates round-robin on conflict, and sequences the memory handshake through a 3-state FSM. It returns read data or write completion to the owning requester, and aborts responses that do not arrive within a bounded wait.

## Interface
Parameters:
- MAX_WAIT, 255, cycles allowed in WAIT_RESP before timeout abort (1..255)
- ERR_DATA, 32'hDEADBEEF, rdata value returned on timeout

Ports:
- clk  in  1  clock; all logic on rising edge
- reset_n  in  1  synchronous active-low reset; one clock, reset synchronous and active-low
- i_req  in  1  fetch request; held with i_addr stable until i_gnt
- i_addr  in  32  fetch word address
- i_gnt  out  1  one-cycle pulse: fetch accepted by memory
- i_rvalid  out  1  one-cycle pulse: i_rdata valid
- i_rdata  out  32  fetched instruction
- d_req  in  1  data request; held with d_we/d_addr/d_wdata stable until d_gnt
- d_we  in  1  1 = store, 0 = load
- d_addr  in  32  data address
- d_wdata  in  32  store data
- d_gnt  out  1  one-cycle pulse: data access accepted
- d_rvalid  out  1  one-cycle pulse: load data valid / store complete
- d_rdata  out  32  load data (0 for stores)
- m_req  out  1  memory request
- m_we  out  1  memory write enable
- m_addr  out  32  memory address
- m_wdata  out  32  memory write data
- m_ready  in  1  memory accepts request this cycle
- m_rvalid  in  1  memory response (read data or write ack), one-cycle pulse
- m_rdata  in  32  memory read data
- busy  out  1  FSM not in IDLE
- timeout_err  out  1  sticky: a timeout occurred since reset

## Operation
- FSM states: IDLE, ISSUE, WAIT_RESP. Reset state: IDLE.
- IDLE behaviour:
  - If any request is pending, latch owner, we, addr and wdata into registers and go to ISSUE.
  - Conflict (i_req and d_req both high): grant the requester that did not win the last grant.
  - last_owner register resets to DATA, so the first conflict after reset goes to fetch.
  - A single request is granted regardless of last_owner.
  - Fetch requests always latch we=0 and wdata=0.
- ISSUE behaviour:
  - m_req=1; m_we/m_addr/m_wdata driven from the latched registers.
  - On m_ready: pulse the owner's gnt combinationally in the same cycle, update last_owner, clear the wait counter, and go to WAIT_RESP.
  - No timeout applies in ISSUE.
- WAIT_RESP behaviour:
  - m_req=0. Wait counter increments each cycle.
  - On m_rvalid: register m_rdata (0 if the transaction is a store) into the owner's rdata, pulse the owner's rvalid next cycle, and go to IDLE.
  - If the counter reaches MAX_WAIT without m_rvalid: go to IDLE, pulse the owner's rvalid with rdata=ERR_DATA, and set timeout_err.
- A late m_rvalid arriving in IDLE or ISSUE is ignored.
- The non-owner's gnt and rvalid stay 0 throughout a transaction.
- Changes to requester inputs after latching have no effect. Dropping req before gnt is illegal; the latched transaction still completes.
- Reset values: all outputs 0, i_rdata/d_rdata 0, timeout_err 0.
  - Reset mid-transaction returns to IDLE, deasserts m_req in the next cycle, and discards the pending response.
  - No gnt or rvalid is emitted for the aborted transaction.

## Timing
- Request sampled at edge n is in ISSUE during cycle n+1. m_req is high from cycle n+1.
- gnt is in the same cycle as m_ready, earliest n+1.
- m_rvalid is legal no earlier than the cycle after m_ready.
- rvalid is one cycle after m_rvalid and coincides with the return to IDLE.
- Minimum round trip is 3 cycles from request sample to rvalid. Back-to-back requests re-enter ISSUE one cycle after rvalid.
- Timeout: rvalid(ERR_DATA) occurs MAX_WAIT+1 cycles after the gnt cycle.
- busy is high in ISSUE and WAIT_RESP.

## Test plan
- Single fetch, i_addr=0x10, m_ready immediate, m_rvalid 2 cycles later with 0x00A00093 -> i_gnt pulses once; i_rvalid pulses with i_rdata=0x00A00093; d_* stay 0.
- Store d_we=1, d_addr=0x200, d_wdata=0x12345678, m_ready delayed 3 cycles -> m_req held 4 cycles with m_we=1 and stable addr/data; d_gnt on the 4th cycle; d_rvalid pulses with d_rdata=0 after m_rvalid.
- i_req and d_req continuously high for 4 transactions -> grant order fetch, data, fetch, data; no gnt or rvalid to the non-owner.
- m_rvalid never arrives, MAX_WAIT=8 -> owner rvalid with rdata=0xDEADBEEF 9 cycles after gnt; timeout_err stays 1; the next transaction completes normally.
- reset_n low for one cycle during WAIT_RESP -> IDLE next cycle with all outputs 0; a subsequent m_rvalid produces no rvalid.
- Requester changes d_addr after latching (before gnt) -> m_addr keeps the originally latched value.
